// File: rtl/xm23_decode_stage.sv
// XM23 decode stage: registered decode of arithmetic-logic, MOV and SWAP
// instructions with a two-entry output/skid buffer and saturating
// statistics counters.
module xm23_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_inst,
    input  logic [15:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_pc,
    output logic [3:0]       out_op,
    output logic             out_rc,
    output logic             out_wb,
    output logic [2:0]       out_src,
    output logic [2:0]       out_dst,
    output logic [15:0]      out_const,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stat_decoded,
    output logic [CNT_W-1:0] stat_illegal
);

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  op;
        logic        rc;
        logic        wb;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [15:0] cnst;
        logic        illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t out_reg;
    entry_t skid_reg;
    logic   out_valid_reg;
    logic   skid_valid_reg;
    logic   accept;
    logic   xfer;
    logic [1:0] cnt_hit;

    // Constant generator table selected by the source field
    function automatic logic [15:0] const_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    const_lut = 16'h0000;
            3'd1:    const_lut = 16'h0001;
            3'd2:    const_lut = 16'h0002;
            3'd3:    const_lut = 16'h0004;
            3'd4:    const_lut = 16'h0008;
            3'd5:    const_lut = 16'h0010;
            3'd6:    const_lut = 16'h0020;
            default: const_lut = 16'hFFFF;
        endcase
    endfunction

    assign in_ready = ~skid_valid_reg;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_reg & out_ready;

    // Split the incoming word into execute control fields
    always_comb begin
        dec_entry         = '0;
        dec_entry.pc      = in_pc;
        dec_entry.src     = in_inst[5:3];
        dec_entry.dst     = in_inst[2:0];
        dec_entry.op      = 4'hF;
        dec_entry.illegal = 1'b1;
        if (in_inst[15:12] == 4'h4 && in_inst[11:8] <= 4'hB) begin
            dec_entry.op      = in_inst[11:8];
            dec_entry.rc      = in_inst[7];
            dec_entry.wb      = in_inst[6];
            dec_entry.illegal = 1'b0;
        end else if (in_inst[15:8] == 8'h4C && !in_inst[7]) begin
            dec_entry.op      = 4'hC;
            dec_entry.wb      = in_inst[6];
            dec_entry.illegal = 1'b0;
        end else if (in_inst[15:8] == 8'h4C && !in_inst[6]) begin
            dec_entry.op      = 4'hD;
            dec_entry.illegal = 1'b0;
        end
        if (dec_entry.rc) begin
            dec_entry.cnst = const_lut(in_inst[5:3]);
        end
    end

    // Output register plus skid register; skid only fills while output stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || xfer) begin
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg       <= dec_entry;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_reg       <= dec_entry;
            skid_valid_reg <= 1'b1;
        end
    end

    // Index 0 counts legal deliveries, index 1 illegal ones
    assign cnt_hit[0] = xfer & ~out_reg.illegal;
    assign cnt_hit[1] = xfer & out_reg.illegal;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] count_reg;
            // Saturating event counter
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (cnt_hit[gi] && count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign stat_decoded = gen_cnt[0].count_reg;
    assign stat_illegal = gen_cnt[1].count_reg;

    assign out_valid   = out_valid_reg;
    assign out_pc      = out_reg.pc;
    assign out_op      = out_reg.op;
    assign out_rc      = out_reg.rc;
    assign out_wb      = out_reg.wb;
    assign out_src     = out_reg.src;
    assign out_dst     = out_reg.dst;
    assign out_const   = out_reg.cnst;
    assign out_illegal = out_reg.illegal;

endmodule
